// File: rtl/spi_sample_sched.sv
// Light-sensor SPI sample scheduler: issues start pulses from a periodic timer or a
// manual request, captures the returned word on SS release and keeps a running mean.
module spi_sample_sched #(
    parameter int PERIOD_CYCLES  = 10_000_000,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int AVG_LOG2       = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        auto_en,
    input  logic        manual_req,
    input  logic        ss_in,
    input  logic [15:0] word_in,
    output logic        spi_start,
    output logic        busy,
    output logic [15:0] word_out,
    output logic [7:0]  sample,
    output logic        sample_valid,
    output logic [7:0]  avg,
    output logic        avg_valid,
    output logic        timeout_err
);

    // state    | meaning
    // IDLE     | waiting for a pending request
    // START    | one-cycle start pulse to the SPI master
    // WAIT_LO  | waiting for SS to fall (transfer begun)
    // WAIT_HI  | waiting for SS to rise (transfer done)
    // LATCH    | capture word, update sample and mean
    // ABORT    | SS wait expired, flag error without capture
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_WAIT_LO,
        ST_WAIT_HI,
        ST_LATCH,
        ST_ABORT
    } state_t;

    localparam int PW = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int AW = 8 + AVG_LOG2;
    localparam int CW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;

    localparam logic [PW-1:0] P_RELOAD = PW'(PERIOD_CYCLES - 1);
    localparam logic [TW-1:0] W_RELOAD = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'((1 << AVG_LOG2) - 1);

    state_t        state;
    state_t        state_nx;
    logic [PW-1:0] prd_cnt;
    logic          tick;
    logic          pending;
    logic [TW-1:0] wait_cnt;
    logic          wait_tc;
    logic          capture_en;
    logic          abort_en;
    logic [7:0]    new_sample;
    logic [AW-1:0] acc;
    logic [AW-1:0] acc_sum;
    logic [CW-1:0] cnt;

    // Period timer: the down-count reaches zero on every PERIOD_CYCLES-th enabled cycle.
    assign tick = auto_en && (prd_cnt == '0);

    always_ff @(posedge clk) begin
        if (!reset) begin
            prd_cnt <= P_RELOAD;
        end else if (!auto_en || prd_cnt == '0) begin
            prd_cnt <= P_RELOAD;
        end else begin
            prd_cnt <= prd_cnt - PW'(1);
        end
    end

    // A new request in the consuming cycle survives as the next pending one.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pending <= 1'b0;
        end else begin
            pending <= (pending && state != ST_IDLE) || manual_req || tick;
        end
    end

    assign wait_tc = (wait_cnt == '0);

    always_ff @(posedge clk) begin
        if (!reset) begin
            wait_cnt <= W_RELOAD;
        end else if (state == ST_START || (state == ST_WAIT_LO && !ss_in)) begin
            wait_cnt <= W_RELOAD;
        end else if ((state == ST_WAIT_LO || state == ST_WAIT_HI) && !wait_tc) begin
            wait_cnt <= wait_cnt - TW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: begin
                if (pending) state_nx = ST_START;
            end
            ST_START: state_nx = ST_WAIT_LO;
            ST_WAIT_LO: begin
                if (!ss_in)       state_nx = ST_WAIT_HI;
                else if (wait_tc) state_nx = ST_ABORT;
            end
            ST_WAIT_HI: begin
                if (ss_in)        state_nx = ST_LATCH;
                else if (wait_tc) state_nx = ST_ABORT;
            end
            ST_LATCH: state_nx = ST_IDLE;
            ST_ABORT: state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        spi_start  = (state == ST_START);
        busy       = (state != ST_IDLE);
        capture_en = (state == ST_LATCH);
        abort_en   = (state == ST_ABORT);
    end

    assign new_sample = word_in[11:4];
    assign acc_sum    = acc + AW'(new_sample);

    // acc holds at most 2^AVG_LOG2-1 samples before the final add, so AW bits never wrap.
    always_ff @(posedge clk) begin
        if (!reset) begin
            word_out     <= '0;
            sample       <= '0;
            sample_valid <= 1'b0;
            avg          <= '0;
            avg_valid    <= 1'b0;
            timeout_err  <= 1'b0;
            acc          <= '0;
            cnt          <= '0;
        end else begin
            sample_valid <= 1'b0;
            avg_valid    <= 1'b0;
            if (capture_en) begin
                word_out     <= word_in;
                sample       <= new_sample;
                sample_valid <= 1'b1;
                timeout_err  <= 1'b0;
                if (cnt == CNT_LAST) begin
                    avg       <= 8'(acc_sum >> AVG_LOG2);
                    avg_valid <= 1'b1;
                    acc       <= '0;
                    cnt       <= '0;
                end else begin
                    acc <= acc_sum;
                    cnt <= cnt + CW'(1);
                end
            end else if (abort_en) begin
                timeout_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_spi_sample_sched.sv
// Directed-random bench for spi_sample_sched with a behavioural SPI slave and a
// sample/mean reference model.
module tb_spi_sample_sched;
    localparam int P = 100;
    localparam int T = 50;
    localparam int L = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        auto_en;
    logic        manual_req;
    logic        ss_in;
    logic [15:0] word_in;
    logic        spi_start;
    logic        busy;
    logic [15:0] word_out;
    logic [7:0]  sample;
    logic        sample_valid;
    logic [7:0]  avg;
    logic        avg_valid;
    logic        timeout_err;

    spi_sample_sched #(
        .PERIOD_CYCLES (P),
        .TIMEOUT_CYCLES(T),
        .AVG_LOG2      (L)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .auto_en     (auto_en),
        .manual_req  (manual_req),
        .ss_in       (ss_in),
        .word_in     (word_in),
        .spi_start   (spi_start),
        .busy        (busy),
        .word_out    (word_out),
        .sample      (sample),
        .sample_valid(sample_valid),
        .avg         (avg),
        .avg_valid   (avg_valid),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    // SPI slave: mode 0 normal, 1 never drops SS, 2 holds SS low for slv_b cycles.
    int          slv_mode = 0;
    int          slv_a = 1;
    int          slv_b = 1;
    int          slv_rise = -1;
    logic [15:0] slv_words[$];

    initial begin
        ss_in   = 1'b1;
        word_in = 16'h0000;
        forever begin
            @(negedge clk);
            if (spi_start === 1'b1 && slv_mode != 1) begin
                repeat (slv_a) @(negedge clk);
                ss_in = 1'b0;
                repeat (slv_b) @(negedge clk);
                if (slv_mode == 0) begin
                    if (slv_words.size() > 0) word_in = slv_words.pop_front();
                    else word_in = 16'($urandom);
                    slv_rise = cyc;
                end
                ss_in = 1'b1;
            end
        end
    end

    int   n_start = 0;
    int   n_sv = 0;
    int   n_av = 0;
    int   last_start = -1;
    int   av_svn = -1;
    logic av_with_sv = 1'b0;
    int   start_q[$];

    initial begin
        forever begin
            @(negedge clk);
            if (spi_start === 1'b1) begin
                n_start++;
                last_start = cyc;
                start_q.push_back(cyc);
            end
            if (sample_valid === 1'b1) n_sv++;
            if (avg_valid === 1'b1) begin
                n_av++;
                av_svn     = n_sv;
                av_with_sv = sample_valid;
            end
        end
    end

    // Reference: samples since the last mean; every 2^L captures yields floor(sum / 2^L).
    logic [7:0] mq[$];

    task automatic model_capture(input logic [15:0] w, output logic eav, output logic [7:0] eavg);
        int s;
        mq.push_back(w[11:4]);
        eav  = 1'b0;
        eavg = 8'h00;
        if (mq.size() == (1 << L)) begin
            s = 0;
            foreach (mq[i]) s += int'(mq[i]);
            eavg = 8'(s / (1 << L));
            eav  = 1'b1;
            mq.delete();
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_sv(input string tag, input int budget);
        int k = 0;
        while (sample_valid !== 1'b1 && k < budget) begin
            step();
            k++;
        end
        n_cmp++;
        assert (k < budget) else begin
            n_err++;
            $error("FAIL %s.sv_wait: observed %0d cycles expected < %0d", tag, k, budget);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, ".spi_start"}, 32'(spi_start), 0);
        chk({tag, ".busy"}, 32'(busy), 0);
        chk({tag, ".word_out"}, 32'(word_out), 0);
        chk({tag, ".sample"}, 32'(sample), 0);
        chk({tag, ".sample_valid"}, 32'(sample_valid), 0);
        chk({tag, ".avg"}, 32'(avg), 0);
        chk({tag, ".avg_valid"}, 32'(avg_valid), 0);
        chk({tag, ".timeout_err"}, 32'(timeout_err), 0);
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b0;
        step();
        chk_reset_outputs(tag);
        reset = 1'b1;
        mq.delete();
        step();
    endtask

    // Called at the sample_valid cycle of a good transfer.
    task automatic check_capture(input string tag, input logic [15:0] w);
        logic       eav;
        logic [7:0] eavg;
        model_capture(w, eav, eavg);
        chk({tag, ".sv_lat"}, cyc, slv_rise + 2);
        chk({tag, ".word"}, 32'(word_out), 32'(w));
        chk({tag, ".sample"}, 32'(sample), 32'(w[11:4]));
        chk({tag, ".err"}, 32'(timeout_err), 0);
        chk({tag, ".avg_valid"}, 32'(avg_valid), 32'(eav));
        if (eav) chk({tag, ".avg"}, 32'(avg), 32'(eavg));
    endtask

    task automatic manual_xfer(input string tag, input logic [15:0] w);
        int r, sb, svb;
        slv_mode = 0;
        slv_a    = int'($urandom_range(1, 10));
        slv_b    = int'($urandom_range(1, 10));
        slv_words.push_back(w);
        sb  = n_start;
        svb = n_sv;
        r   = cyc;
        manual_req = 1'b1;
        step();
        manual_req = 1'b0;
        wait_sv(tag, 100);
        chk({tag, ".start_lat"}, last_start, r + 2);
        check_capture(tag, w);
        chk({tag, ".busy"}, 32'(busy), 0);
        step();
        chk({tag, ".sv_pulse"}, 32'(sample_valid), 0);
        chk({tag, ".n_start"}, n_start - sb, 1);
        chk({tag, ".n_sv"}, n_sv - svb, 1);
    endtask

    task automatic timeout_xfer(input string tag);
        int r, svb;
        logic [15:0] wprev;
        slv_mode = 1;
        wprev    = word_out;
        svb      = n_sv;
        r        = cyc;
        manual_req = 1'b1;
        step();
        manual_req = 1'b0;
        while (cyc < r + T + 3) step();
        chk({tag, ".err_pre"}, 32'(timeout_err), 0);
        chk({tag, ".busy_pre"}, 32'(busy), 1);
        step();
        chk({tag, ".err"}, 32'(timeout_err), 1);
        chk({tag, ".busy"}, 32'(busy), 0);
        chk({tag, ".word_kept"}, 32'(word_out), 32'(wprev));
        chk({tag, ".no_sv"}, n_sv - svb, 0);
        chk({tag, ".start_lat"}, last_start, r + 2);
        slv_mode = 0;
    endtask

    task automatic stuck_xfer(input string tag);
        int r, a, svb;
        a        = int'($urandom_range(1, 5));
        slv_a    = a;
        slv_b    = 70;
        slv_mode = 2;
        svb      = n_sv;
        r        = cyc;
        manual_req = 1'b1;
        step();
        manual_req = 1'b0;
        while (cyc < r + a + T + 3) step();
        chk({tag, ".err_pre"}, 32'(timeout_err), 0);
        chk({tag, ".busy_pre"}, 32'(busy), 1);
        step();
        chk({tag, ".err"}, 32'(timeout_err), 1);
        chk({tag, ".busy"}, 32'(busy), 0);
        chk({tag, ".no_sv"}, n_sv - svb, 0);
        while (cyc < r + a + 75) step();
        slv_mode = 0;
    endtask

    int          r, e0, sb, svb, avb, h1, k;
    logic        eav;
    logic [7:0]  eavg;
    logic [15:0] w1, w2;
    logic [15:0] pw[4];
    logic [7:0]  psamp[4];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b0;
        auto_en    = 1'b0;
        manual_req = 1'b0;
        psamp[0] = 8'h10;
        psamp[1] = 8'h20;
        psamp[2] = 8'h30;
        psamp[3] = 8'h41;
        repeat (3) step();
        chk_reset_outputs("init");
        reset = 1'b1;
        step();

        manual_xfer("t1", 16'h0AB0);

        // Periodic sampling for 450 enabled cycles
        do_reset("t2rst");
        slv_mode = 0;
        slv_a    = int'($urandom_range(1, 10));
        slv_b    = int'($urandom_range(1, 10));
        for (int i = 0; i < 4; i++) begin
            pw[i] = {4'($urandom), psamp[i], 4'($urandom)};
            slv_words.push_back(pw[i]);
        end
        start_q.delete();
        sb  = n_start;
        svb = n_sv;
        avb = n_av;
        e0  = cyc;
        auto_en = 1'b1;
        repeat (450) step();
        auto_en = 1'b0;
        repeat (150) step();
        chk("t2.n_start", n_start - sb, 4);
        for (int i = 0; i < 4; i++)
            chk("t2.start_cyc", (i < start_q.size()) ? start_q[i] : -1, e0 + P + 1 + P * i);
        for (int i = 0; i < 4; i++) model_capture(pw[i], eav, eavg);
        chk("t2.n_sv", n_sv - svb, 4);
        chk("t2.n_av", n_av - avb, 1);
        chk("t2.av_on_4th", av_svn, svb + 4);
        chk("t2.av_with_sv", 32'(av_with_sv), 1);
        chk("t2.avg_flag_model", 32'(eav), 32'(avg_valid | 1'b1));
        chk("t2.avg", 32'(avg), 32'(eavg));
        chk("t2.sample", 32'(sample), 32'(psamp[3]));
        chk("t2.word", 32'(word_out), 32'(pw[3]));

        // Three requests during a transfer collapse into one follow-up
        slv_mode = 0;
        slv_a    = 5;
        slv_b    = 20;
        w1 = 16'($urandom);
        w2 = 16'($urandom);
        slv_words.push_back(w1);
        slv_words.push_back(w2);
        sb = n_start;
        r  = cyc;
        manual_req = 1'b1;
        step();
        manual_req = 1'b0;
        while (cyc < r + 6) step();
        repeat (3) begin
            manual_req = 1'b1;
            step();
            manual_req = 1'b0;
            repeat (3) step();
        end
        wait_sv("t3a", 60);
        check_capture("t3a", w1);
        h1 = slv_rise;
        k  = 0;
        while (n_start - sb < 2 && k < 40) begin
            step();
            k++;
        end
        chk("t3.start2_lat", last_start, h1 + 3);
        wait_sv("t3b", 60);
        check_capture("t3b", w2);
        repeat (100) step();
        chk("t3.n_start", n_start - sb, 2);

        timeout_xfer("t4");
        manual_xfer("t4good", 16'($urandom));

        // Stuck-low abort must not advance the averaging count
        stuck_xfer("t6");
        manual_xfer("t6a", 16'($urandom));
        manual_xfer("t6b", 16'($urandom));
        manual_xfer("t6c", 16'($urandom));

        // Reset in WAIT_HI abandons the transfer
        timeout_xfer("t5prep");
        slv_mode = 0;
        slv_a    = 3;
        slv_b    = 30;
        slv_words.push_back(16'($urandom));
        svb = n_sv;
        r   = cyc;
        manual_req = 1'b1;
        step();
        manual_req = 1'b0;
        while (cyc < r + 12) step();
        chk("t5.busy_pre", 32'(busy), 1);
        reset = 1'b0;
        step();
        chk_reset_outputs("t5");
        reset = 1'b1;
        mq.delete();
        while (cyc < r + 45) step();
        chk("t5.no_sv", n_sv - svb, 0);
        chk("t5.busy_post", 32'(busy), 0);
        chk("t5.word_post", 32'(word_out), 0);

        manual_xfer("t5post", 16'($urandom));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
